// File: rtl/burst_write_sequencer_if.sv
// AXI4 write-channel bundle (AW, W, B) between the burst sequencer and the memory side.
interface burst_write_sequencer_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 32
);
    logic                  m_awvalid;
    logic                  m_awready;
    logic [ADDR_W-1:0]     m_awaddr;
    logic [7:0]            m_awlen;
    logic                  m_wvalid;
    logic                  m_wready;
    logic [DATA_W-1:0]     m_wdata;
    logic [DATA_W/8-1:0]   m_wstrb;
    logic                  m_wlast;
    logic                  m_bvalid;
    logic                  m_bready;
    logic [1:0]            m_bresp;

    modport master (
        output m_awvalid, m_awaddr, m_awlen,
        output m_wvalid, m_wdata, m_wstrb, m_wlast,
        output m_bready,
        input  m_awready, m_wready, m_bvalid, m_bresp
    );

    modport slave (
        input  m_awvalid, m_awaddr, m_awlen,
        input  m_wvalid, m_wdata, m_wstrb, m_wlast,
        input  m_bready,
        output m_awready, m_wready, m_bvalid, m_bresp
    );
endinterface

// File: rtl/burst_write_sequencer.sv
// Pops a beat count, then drains that many data-FIFO words onto AXI4 as bursts of at most
// MAX_BURST beats that never cross 4 KB; completion is reported with ap_ctrl_hs.
module burst_write_sequencer #(
    parameter int unsigned ADDR_W          = 64,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned LEN_W           = 32,
    parameter int unsigned MAX_BURST       = 16,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_done,
    output logic                 ap_ready,
    output logic                 ap_idle,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [LEN_W-1:0]     count_dout,
    input  logic                 count_empty_n,
    output logic                 count_read,
    input  logic [DATA_W-1:0]    buf_dout,
    input  logic                 buf_empty_n,
    output logic                 buf_read,
    output logic                 err,
    burst_write_sequencer_if.master axi
);

    localparam int unsigned BYTES_PER_BEAT = DATA_W / 8;
    localparam int unsigned ADDR_LSB       = $clog2(BYTES_PER_BEAT);
    localparam int unsigned OUT_W          = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_CNT,
        S_ISSUE_AW,
        S_DATA,
        S_WAIT_B,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    remaining_q, remaining_d;
    logic [8:0]          blen_q, blen_d;
    logic [8:0]          beat_q, beat_d;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic                err_q, err_d;

    logic                live;
    logic [ADDR_W-1:0]   base_aligned;
    logic [12:0]         page_beats;
    logic [12:0]         burst_cap;
    logic [8:0]          blen_c;
    logic                awvalid_c, wvalid_c, wlast_c;
    logic                count_read_c, buf_read_c, done_c;
    logic                aw_fire, w_fire, b_fire;

    // Every output is forced low while reset is asserted, including the B ready.
    assign live         = ~ap_rst;
    assign base_aligned = base_addr & ~ADDR_W'(BYTES_PER_BEAT - 1);

    // Burst length: smallest of remaining beats, MAX_BURST and beats left in the 4 KB page.
    always_comb begin
        page_beats = (13'd4096 - {1'b0, addr_q[11:0]}) >> ADDR_LSB;
        burst_cap  = (page_beats < 13'(MAX_BURST)) ? page_beats : 13'(MAX_BURST);
        blen_c     = (remaining_q < LEN_W'(burst_cap)) ? 9'(remaining_q) : 9'(burst_cap);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        blen_d        = blen_q;
        beat_d        = beat_q;
        err_d         = err_q;
        outstanding_d = outstanding_q;
        awvalid_c     = 1'b0;
        wvalid_c      = 1'b0;
        wlast_c       = 1'b0;
        count_read_c  = 1'b0;
        buf_read_c    = 1'b0;
        done_c        = 1'b0;
        aw_fire       = 1'b0;
        w_fire        = 1'b0;
        b_fire        = axi.m_bvalid && (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (ap_start) begin
                    addr_d  = base_aligned;
                    err_d   = 1'b0;
                    state_d = S_GET_CNT;
                end
            end
            S_GET_CNT: begin
                count_read_c = count_empty_n;
                if (count_empty_n) begin
                    remaining_d = count_dout;
                    state_d     = (count_dout == '0) ? S_WAIT_B : S_ISSUE_AW;
                end
            end
            S_ISSUE_AW: begin
                awvalid_c = (outstanding_q != OUT_W'(MAX_OUTSTANDING));
                aw_fire   = awvalid_c && axi.m_awready;
                if (aw_fire) begin
                    addr_d      = addr_q + (ADDR_W'(blen_c) << ADDR_LSB);
                    remaining_d = remaining_q - LEN_W'(blen_c);
                    blen_d      = blen_c;
                    beat_d      = '0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                wvalid_c   = buf_empty_n;
                wlast_c    = (beat_q == blen_q - 9'd1);
                w_fire     = wvalid_c && axi.m_wready;
                buf_read_c = w_fire;
                if (w_fire) begin
                    beat_d = beat_q + 9'd1;
                    if (wlast_c) begin
                        state_d = (remaining_q != '0) ? S_ISSUE_AW : S_WAIT_B;
                    end
                end
            end
            S_WAIT_B: begin
                if (outstanding_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_c  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (b_fire && (axi.m_bresp != 2'b00)) begin
            err_d = 1'b1;
        end

        // A simultaneous AW handshake and B response cancel out.
        if (aw_fire && !b_fire) begin
            outstanding_d = outstanding_q + 1'b1;
        end else if (b_fire && !aw_fire) begin
            outstanding_d = outstanding_q - 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            blen_q        <= '0;
            beat_q        <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            blen_q        <= blen_d;
            beat_q        <= beat_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
        end
    end

    assign ap_done    = live & done_c;
    assign ap_ready   = live & done_c;
    assign ap_idle    = live & (state_q == S_IDLE);
    assign count_read = live & count_read_c;
    assign buf_read   = live & buf_read_c;
    assign err        = live & err_q;

    assign axi.m_awvalid = live & awvalid_c;
    assign axi.m_awaddr  = (live && state_q == S_ISSUE_AW) ? addr_q : '0;
    assign axi.m_awlen   = (live && state_q == S_ISSUE_AW) ? 8'(blen_c - 9'd1) : '0;
    assign axi.m_wvalid  = live & wvalid_c;
    assign axi.m_wdata   = live ? buf_dout : '0;
    assign axi.m_wstrb   = {(DATA_W/8){live}};
    assign axi.m_wlast   = live & wlast_c;
    assign axi.m_bready  = live;

endmodule
